instr_feeder: RTL

INSTR_FEEDER -- requirements
Module: instr_feeder

---
 rtl/instr_feeder_pkg.sv | 36 +++
 rtl/instr_feeder_prog_mem.sv | 24 ++
 rtl/instr_feeder.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/instr_feeder_pkg.sv
// Shared constants, instruction field layout and FSM encoding for the instruction feeder.
package instr_feeder_pkg;

  localparam int unsigned WORD_W = 16;
  localparam int unsigned ADDR_W = 5;
  localparam int unsigned LEN_W  = 6;

  // Instruction word layout: III XXX YYY in bits [15:7]
  localparam int unsigned OP_HI = 15;
  localparam int unsigned OP_LO = 13;
  localparam int unsigned X_HI  = 12;
  localparam int unsigned X_LO  = 10;
  localparam int unsigned Y_HI  = 9;
  localparam int unsigned Y_LO  = 7;
  localparam int unsigned OP_W  = OP_HI - OP_LO + 1;

  localparam logic [OP_W-1:0] OP_MV  = 3'b000;
  localparam logic [OP_W-1:0] OP_MVI = 3'b001;
  localparam logic [OP_W-1:0] OP_ADD = 3'b010;
  localparam logic [OP_W-1:0] OP_SUB = 3'b011;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    IMM   = 3'd2,
    WAIT  = 3'd3,
    HALT  = 3'd4,
    ERR   = 3'd5
  } state_t;

  // Extract the opcode field of an instruction word.
  function automatic logic [OP_W-1:0] opcode_of(input logic [WORD_W-1:0] word);
    return word[OP_HI:OP_LO];
  endfunction

endpackage

// File: rtl/instr_feeder_prog_mem.sv
// Program memory: synchronous write, asynchronous read, contents survive reset.
module prog_mem
  import instr_feeder_pkg::*;
#(
  parameter int unsigned DEPTH = 32
) (
  input  logic              Clock,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WORD_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WORD_W-1:0] rd_data_c
);

  logic [WORD_W-1:0] mem [DEPTH];

  // Write port; deliberately no reset so programs persist across resets.
  always_ff @(posedge Clock) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rd_data_c = mem[raddr];

endmodule

// File: rtl/instr_feeder.sv
// Instruction feeder: streams program words to a processor, one instruction per Done handshake.
module instr_feeder
  import instr_feeder_pkg::*;
#(
  parameter int unsigned DEPTH   = 32,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              ProgWe,
  input  logic [ADDR_W-1:0] ProgAddr,
  input  logic [WORD_W-1:0] ProgData,
  input  logic [LEN_W-1:0]  ProgLen,
  input  logic              Start,
  input  logic              Done,
  output logic [WORD_W-1:0] DIN,
  output logic              Run,
  output logic              Busy,
  output logic              Halted,
  output logic              Error,
  output logic [ADDR_W-1:0] PC
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  state_t             state;
  logic [LEN_W-1:0]   len_q;
  // One bit wider than PC so an mvi at address 31 of a full program still halts.
  logic [LEN_W-1:0]   pc_q;
  logic [CNT_W-1:0]   cnt;

  logic               wr_en_c;
  logic [ADDR_W-1:0]  rd_addr_c;
  logic [WORD_W-1:0]  rd_data_c;
  logic [WORD_W-1:0]  fetch_c;

  assign PC      = pc_q[ADDR_W-1:0];
  assign wr_en_c = ProgWe && !Busy && !Reset;

  prog_mem #(.DEPTH(DEPTH)) u_mem (
    .Clock     (Clock),
    .we        (wr_en_c),
    .waddr     (ProgAddr),
    .wdata     (ProgData),
    .raddr     (rd_addr_c),
    .rd_data_c (rd_data_c)
  );

  // Look-ahead fetch address: the word DIN will carry in the next state.
  always_comb begin
    rd_addr_c = '0;
    case (state)
      ISSUE:   rd_addr_c = pc_q[ADDR_W-1:0] + ADDR_W'(1);
      WAIT:    rd_addr_c = pc_q[ADDR_W-1:0];
      default: rd_addr_c = '0;
    endcase
  end

  // Forward a write landing on the same edge as Start so DIN matches the updated array.
  always_comb begin
    fetch_c = rd_data_c;
    if (wr_en_c && (ProgAddr == rd_addr_c)) fetch_c = ProgData;
  end

  // Sequencer FSM with timeout counter; all outputs registered alongside the state.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state  <= IDLE;
      len_q  <= '0;
      pc_q   <= '0;
      cnt    <= '0;
      DIN    <= '0;
      Run    <= 1'b0;
      Busy   <= 1'b0;
      Halted <= 1'b0;
      Error  <= 1'b0;
    end else begin
      Run <= 1'b0;
      DIN <= '0;
      case (state)
        IDLE, HALT, ERR: begin
          if (Start) begin
            len_q  <= ProgLen;
            pc_q   <= '0;
            cnt    <= '0;
            Error  <= 1'b0;
            if (ProgLen == '0) begin
              state  <= HALT;
              Halted <= 1'b1;
            end else begin
              state  <= ISSUE;
              Halted <= 1'b0;
              Busy   <= 1'b1;
              Run    <= 1'b1;
              DIN    <= fetch_c;
            end
          end
        end
        ISSUE: begin
          pc_q <= pc_q + LEN_W'(1);
          cnt  <= '0;
          if (opcode_of(DIN) == OP_MVI) begin
            state <= IMM;
            DIN   <= fetch_c;
          end else begin
            state <= WAIT;
          end
        end
        IMM: begin
          pc_q  <= pc_q + LEN_W'(1);
          cnt   <= '0;
          state <= WAIT;
        end
        WAIT: begin
          if (Done) begin
            if (pc_q >= len_q) begin
              state  <= HALT;
              Busy   <= 1'b0;
              Halted <= 1'b1;
            end else begin
              state <= ISSUE;
              Run   <= 1'b1;
              DIN   <= fetch_c;
            end
          end else if (cnt == CNT_W'(TIMEOUT)) begin
            state <= ERR;
            Busy  <= 1'b0;
            Error <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          state <= IDLE;
          Busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
